// File: rtl/ber_sweep_pkg.sv
// Shared types and constants for the BER sweep sequencer and its result memory.
package ber_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ERST = 3'd1,
        ST_LOAD = 3'd2,
        ST_ARM  = 3'd3,
        ST_RUN  = 3'd4,
        ST_CAPT = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    localparam logic [31:0] PROB_IDX_IDLE = 32'hFFFF_FFFF;

    localparam int RES_BITS      = 0;
    localparam int RES_ERR_PRE   = 1;
    localparam int RES_ERR_POST  = 2;
    localparam int RES_FRAMES    = 3;
    localparam int RES_FRAME_ERR = 4;
    localparam int RES_COUNT     = 5;

    localparam int RUN_HOLDOFF = 2;

endpackage

// File: rtl/ber_sweep_result_ram.sv
// Per-point snapshot of the five engine counters; one wide write port, registered read.
module ber_sweep_result_ram
    import ber_sweep_pkg::*;
#(
    parameter int N_POINTS = 8,
    parameter int CNT_W    = 64,
    localparam int PW      = (N_POINTS > 1) ? $clog2(N_POINTS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 we,
    input  logic [PW-1:0]                        waddr,
    input  logic [RES_COUNT-1:0][CNT_W-1:0]      wdata,
    input  logic [PW-1:0]                        rpoint,
    input  logic [2:0]                           rsel,
    output logic [CNT_W-1:0]                     rdata
);

    logic [RES_COUNT-1:0][CNT_W-1:0] mem [N_POINTS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Out-of-range selectors read as zero rather than whatever the array holds.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata <= '0;
        end else if ((32'(rsel) < RES_COUNT) && (32'(rpoint) < N_POINTS)) begin
            rdata <= mem[rpoint][rsel];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/ber_sweep_sequencer.sv
// Autonomous SNR sweep: per point reset, load, arm and run the BER engine, then snapshot counters.
// Optional BER_SWEEP_ERR_STOP_EN also ends a point on the post-FEC error limit.
module ber_sweep_sequencer
    import ber_sweep_pkg::*;
#(
    parameter int N_POINTS    = 8,
    parameter int TABLE_DEPTH = 64,
    parameter int PROB_W      = 64,
    parameter int CNT_W       = 64,
    localparam int PW = (N_POINTS > 1) ? $clog2(N_POINTS) : 1,
    localparam int AW = (N_POINTS * TABLE_DEPTH > 1) ? $clog2(N_POINTS * TABLE_DEPTH) : 1,
    localparam int NW = $clog2(N_POINTS + 1),
    localparam int IW = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1,
    localparam int RW = $clog2(RUN_HOLDOFF + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [PROB_W-1:0] cfg_data,
    input  logic              cfg_il_we,
    input  logic [CNT_W-1:0]  bit_limit,
    input  logic [CNT_W-1:0]  err_limit,
    input  logic [NW-1:0]     n_points,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [PW-1:0]     cur_point,
    output logic              eng_en,
    output logic              eng_rstn,
    output logic [PROB_W-1:0] eng_prob_in,
    output logic [31:0]       eng_prob_idx,
    output logic [3:0]        eng_n_interleave,
    input  logic [CNT_W-1:0]  total_bits,
    input  logic [CNT_W-1:0]  total_bit_errors_pre,
    input  logic [CNT_W-1:0]  total_bit_errors_post,
    input  logic [CNT_W-1:0]  total_frames,
    input  logic [CNT_W-1:0]  total_frame_errors,
    input  logic [PW-1:0]     res_point,
    input  logic [2:0]        res_sel,
    output logic [CNT_W-1:0]  res_data,
    output state_t            fsm_state
);

    state_t                          state, state_next;
    logic [PW-1:0]                   cur_next, last_point;
    logic [IW-1:0]                   load_idx, load_idx_next;
    logic [RW-1:0]                   run_cnt;
    logic                            holdoff_done, stop, start_acc, cfg_ok;
    logic [RES_COUNT-1:0][CNT_W-1:0] cnt_q;
    logic [AW-1:0]                   rd_addr;
    logic [31:0]                     il_pt;
    logic [PROB_W-1:0]               tbl [N_POINTS*TABLE_DEPTH];
    logic [3:0]                      il_regs [N_POINTS];

    assign fsm_state     = state;
    assign cfg_ok        = (state == ST_IDLE) || (state == ST_DONE);
    assign holdoff_done  = (run_cnt == RW'(RUN_HOLDOFF));
    assign load_idx_next = (state == ST_LOAD) ? load_idx + 1'b1 : '0;
    assign rd_addr       = AW'(32'(cur_point) * TABLE_DEPTH + 32'(load_idx_next));
    assign il_pt         = 32'(cfg_addr) / TABLE_DEPTH;

    always_comb begin
        last_point = '0;
        if (n_points == '0) begin
            last_point = '0;
        end else if (32'(n_points) > N_POINTS) begin
            last_point = PW'(N_POINTS - 1);
        end else begin
            last_point = PW'(32'(n_points) - 32'd1);
        end
    end

    always_comb begin
        stop = (cnt_q[RES_BITS] >= bit_limit);
`ifdef BER_SWEEP_ERR_STOP_EN
        if ((err_limit != '0) && (cnt_q[RES_ERR_POST] >= err_limit)) begin
            stop = 1'b1;
        end
`endif
    end

`ifndef BER_SWEEP_ERR_STOP_EN
    logic unused_err_limit;
    assign unused_err_limit = ^err_limit;
`endif

    always_comb begin
        state_next = state;
        cur_next   = cur_point;
        start_acc  = 1'b0;
        case (state)
            ST_IDLE: if (start) begin
                start_acc  = 1'b1;
                state_next = ST_ERST;
                cur_next   = '0;
            end
            ST_ERST: state_next = ST_LOAD;
            ST_LOAD: if (load_idx == IW'(TABLE_DEPTH - 1)) state_next = ST_ARM;
            ST_ARM:  state_next = ST_RUN;
            ST_RUN:  if (holdoff_done && stop) state_next = ST_CAPT;
            ST_CAPT: if (cur_point == last_point) begin
                state_next = ST_DONE;
            end else begin
                state_next = ST_ERST;
                cur_next   = cur_point + 1'b1;
            end
            ST_DONE: if (start && !abort) begin
                start_acc  = 1'b1;
                state_next = ST_ERST;
                cur_next   = '0;
            end
            default: state_next = ST_IDLE;
        endcase
        // Start beats abort only from IDLE; everywhere else abort returns home.
        if (abort && (state != ST_IDLE)) begin
            state_next = ST_IDLE;
            cur_next   = cur_point;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= ST_IDLE;
            cur_point        <= '0;
            load_idx         <= '0;
            run_cnt          <= '0;
            cnt_q            <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            aborted          <= 1'b0;
            eng_en           <= 1'b0;
            eng_rstn         <= 1'b0;
            eng_prob_idx     <= PROB_IDX_IDLE;
            eng_n_interleave <= 4'd1;
        end else begin
            state     <= state_next;
            cur_point <= cur_next;
            load_idx  <= load_idx_next;
            if (state != ST_RUN) begin
                run_cnt <= '0;
            end else if (!holdoff_done) begin
                run_cnt <= run_cnt + 1'b1;
            end
            cnt_q <= {total_frame_errors, total_frames, total_bit_errors_post,
                      total_bit_errors_pre, total_bits};
            busy  <= state_next inside {ST_ERST, ST_LOAD, ST_ARM, ST_RUN, ST_CAPT};
            if (start_acc) begin
                done <= 1'b0;
            end else if ((state_next == ST_DONE) && (state != ST_DONE)) begin
                done <= 1'b1;
            end
            if (start_acc) begin
                aborted <= 1'b0;
            end else if (abort && (state != ST_IDLE)) begin
                aborted <= 1'b1;
            end
            eng_en       <= (state_next == ST_RUN);
            eng_rstn     <= (state_next == ST_RUN);
            eng_prob_idx <= (state_next == ST_LOAD) ? 32'(load_idx_next) : PROB_IDX_IDLE;
            if (state_next == ST_ERST) begin
                eng_n_interleave <= il_regs[cur_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_ok && cfg_we && (32'(cfg_addr) < N_POINTS * TABLE_DEPTH)) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

    // Read one entry ahead so index and data leave on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            eng_prob_in <= '0;
        end else if (state_next == ST_LOAD) begin
            eng_prob_in <= tbl[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_POINTS; i++) il_regs[i] <= 4'd1;
        end else if (cfg_ok && cfg_il_we && (il_pt < N_POINTS)) begin
            il_regs[PW'(il_pt)] <= cfg_data[3:0];
        end
    end

    ber_sweep_result_ram #(
        .N_POINTS (N_POINTS),
        .CNT_W    (CNT_W)
    ) u_result_ram (
        .clk    (clk),
        .rstn   (rstn),
        .we     (state == ST_CAPT),
        .waddr  (cur_point),
        .wdata  (cnt_q),
        .rpoint (res_point),
        .rsel   (res_sel),
        .rdata  (res_data)
    );

endmodule

// File: tb/tb_ber_sweep_sequencer.sv
// Directed bench for ber_sweep_sequencer with a stub BER engine driving the counter inputs.
`timescale 1ns/1ps
module tb_ber_sweep_sequencer;
    import ber_sweep_pkg::*;

    localparam int N_POINTS    = 2;
    localparam int TABLE_DEPTH = 64;
    localparam int PROB_W      = 64;
    localparam int CNT_W       = 64;
    localparam int PW          = 1;
    localparam int AW          = 7;
    localparam int NW          = 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              cfg_we = 1'b0, cfg_il_we = 1'b0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [PROB_W-1:0] cfg_data = '0;
    logic [CNT_W-1:0]  bit_limit = '0, err_limit = '0;
    logic [NW-1:0]     n_points = '0;
    logic              start = 1'b0, abort = 1'b0;
    logic              busy, done, aborted, eng_en, eng_rstn;
    logic [PW-1:0]     cur_point;
    logic [PROB_W-1:0] eng_prob_in;
    logic [31:0]       eng_prob_idx;
    logic [3:0]        eng_n_interleave;
    logic [CNT_W-1:0]  s_bits = '0, s_pre = '0, s_post = '0, s_frames = '0, s_ferr = '0;
    logic [1:0]        s_phase = '0;
    logic [PW-1:0]     res_point = '0;
    logic [2:0]        res_sel = '0;
    logic [CNT_W-1:0]  res_data;
    state_t            fsm_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ber_sweep_sequencer #(
        .N_POINTS (N_POINTS), .TABLE_DEPTH (TABLE_DEPTH), .PROB_W (PROB_W), .CNT_W (CNT_W)
    ) dut (
        .clk (clk), .rstn (rstn),
        .cfg_we (cfg_we), .cfg_addr (cfg_addr), .cfg_data (cfg_data), .cfg_il_we (cfg_il_we),
        .bit_limit (bit_limit), .err_limit (err_limit), .n_points (n_points),
        .start (start), .abort (abort),
        .busy (busy), .done (done), .aborted (aborted), .cur_point (cur_point),
        .eng_en (eng_en), .eng_rstn (eng_rstn), .eng_prob_in (eng_prob_in),
        .eng_prob_idx (eng_prob_idx), .eng_n_interleave (eng_n_interleave),
        .total_bits (s_bits), .total_bit_errors_pre (s_pre), .total_bit_errors_post (s_post),
        .total_frames (s_frames), .total_frame_errors (s_ferr),
        .res_point (res_point), .res_sel (res_sel), .res_data (res_data),
        .fsm_state (fsm_state)
    );

    // Stub engine: +10 bits, +3 pre errors, +1 frame, +2 frame errors per enabled cycle,
    // +1 post error every third enabled cycle.
    always @(posedge clk) begin
        if (!eng_rstn) begin
            s_bits <= '0; s_pre <= '0; s_post <= '0; s_frames <= '0; s_ferr <= '0; s_phase <= '0;
        end else if (eng_en) begin
            s_bits   <= s_bits + 64'd10;
            s_pre    <= s_pre + 64'd3;
            s_frames <= s_frames + 64'd1;
            s_ferr   <= s_ferr + 64'd2;
            if (s_phase == 2'd2) begin
                s_phase <= '0;
                s_post  <= s_post + 64'd1;
            end else begin
                s_phase <= s_phase + 2'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_state(input state_t st, input int limit, input string tag, output int n);
        n = 0;
        while (fsm_state !== st && n < limit) begin
            tick();
            n++;
        end
        check(tag, fsm_state, st);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic read_res(input int p, input int sel, input logic [63:0] exp, input string tag);
        res_point = p[PW-1:0];
        res_sel   = sel[2:0];
        tick();
        check(tag, res_data, exp);
    endtask

    // Entered in ERST; leaves one cycle after CAPT.
    task automatic run_point(input int p, input logic [3:0] il, input int exp_run);
        int n;
        check("erst_state", fsm_state, ST_ERST);
        check("erst_point", cur_point, p);
        check("erst_il", eng_n_interleave, il);
        check("erst_rstn", eng_rstn, 1'b0);
        check("erst_busy", busy, 1'b1);
        for (int k = 0; k < TABLE_DEPTH; k++) begin
            tick();
            check("load_state", fsm_state, ST_LOAD);
            check("load_idx", eng_prob_idx, k);
            check("load_data", eng_prob_in, p * TABLE_DEPTH + k);
        end
        tick();
        check("arm_state", fsm_state, ST_ARM);
        check("arm_idx", eng_prob_idx, 32'hFFFF_FFFF);
        check("arm_rstn", eng_rstn, 1'b0);
        tick();
        check("run_en", eng_en, 1'b1);
        check("run_rstn", eng_rstn, 1'b1);
        n = 0;
        while (fsm_state === ST_RUN && n < 5000) begin
            tick();
            n++;
        end
        check("run_cycles", n, exp_run);
        check("capt_state", fsm_state, ST_CAPT);
        check("capt_en", eng_en, 1'b0);
        check("capt_busy", busy, 1'b1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) tick();
        check("rst_state", fsm_state, ST_IDLE);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_aborted", aborted, 1'b0);
        check("rst_point", cur_point, 0);
        check("rst_en", eng_en, 1'b0);
        check("rst_rstn", eng_rstn, 1'b0);
        check("rst_idx", eng_prob_idx, 32'hFFFF_FFFF);
        check("rst_prob", eng_prob_in, 0);
        check("rst_il", eng_n_interleave, 4'd1);
        check("rst_res", res_data, 0);
        rstn = 1'b1;

        // Tables hold their own word address; interleave 4 and 7.
        for (int a = 0; a < N_POINTS * TABLE_DEPTH; a++) begin
            cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = 64'(a);
            tick();
        end
        cfg_we = 1'b0;
        cfg_il_we = 1'b1; cfg_addr = AW'(0); cfg_data = 64'd4; tick();
        cfg_addr = AW'(TABLE_DEPTH); cfg_data = 64'd7; tick();
        cfg_il_we = 1'b0;

        // Sweep 1: two points, bit_limit 1000 -> 102 RUN cycles, capture 1010 bits.
        n_points = 2'd2; bit_limit = 64'd1000; err_limit = 64'd0;
        pulse_start();
        run_point(0, 4'd4, 102);
        run_point(1, 4'd7, 102);
        check("done_state", fsm_state, ST_DONE);
        check("done_flag", done, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_idx", eng_prob_idx, 32'hFFFF_FFFF);
        check("done_en", eng_en, 1'b0);
        read_res(0, 0, 64'd1010, "res0_bits");
        read_res(0, 1, 64'd303, "res0_pre");
        read_res(0, 2, 64'd33, "res0_post");
        read_res(0, 3, 64'd101, "res0_frames");
        read_res(0, 4, 64'd202, "res0_ferr");
        read_res(0, 5, 64'd0, "res0_sel5");
        read_res(1, 0, 64'd1010, "res1_bits");
        read_res(1, 3, 64'd101, "res1_frames");

        // Sweep 2: error limit 5 with bit_limit 2000.
        n_points = 2'd1; bit_limit = 64'd2000; err_limit = 64'd5;
        pulse_start();
        check("err_erst", fsm_state, ST_ERST);
        check("err_done_clr", done, 1'b0);
        wait_state(ST_DONE, 5000, "err_reach_done", n);
`ifdef BER_SWEEP_ERR_STOP_EN
        check("err_cycles", n, 84);
        read_res(0, 0, 64'd160, "err_bits");
        read_res(0, 2, 64'd5, "err_post");
`else
        check("err_cycles", n, 269);
        read_res(0, 0, 64'd2010, "err_bits");
        read_res(0, 2, 64'd67, "err_post");
`endif

        // Sweep 3: abort in the middle of point 1 LOAD.
        n_points = 2'd2; bit_limit = 64'd500; err_limit = 64'd0;
        pulse_start();
        check("ab_done_clr", done, 1'b0);
        n = 0;
        while (!(fsm_state === ST_LOAD && cur_point === 1'b1) && n < 2000) begin
            tick();
            n++;
        end
        check("ab_reach_load1", fsm_state, ST_LOAD);
        repeat (10) tick();
        check("ab_mid_idx", eng_prob_idx, 32'd10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_state", fsm_state, ST_IDLE);
        check("ab_flag", aborted, 1'b1);
        check("ab_busy", busy, 1'b0);
        check("ab_en", eng_en, 1'b0);
        check("ab_done", done, 1'b0);
        read_res(0, 0, 64'd510, "ab_res0_bits");
        read_res(0, 3, 64'd51, "ab_res0_frames");
        read_res(1, 0, 64'd1010, "ab_res1_kept");

        // Sweep 4: n_points=0, bit_limit=0, start with abort, table write while busy.
        n_points = 2'd0; bit_limit = 64'd0;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("sa_state", fsm_state, ST_ERST);
        check("sa_aborted_clr", aborted, 1'b0);
        check("sa_busy", busy, 1'b1);
        tick();
        cfg_we = 1'b1; cfg_addr = AW'(0); cfg_data = 64'hDEAD_BEEF;
        tick();
        cfg_we = 1'b0;
        wait_state(ST_DONE, 500, "np0_reach_done", n);
        check("np0_cycles", n, 68);
        check("np0_point", cur_point, 0);
        check("np0_done", done, 1'b1);
        read_res(0, 0, 64'd20, "np0_bits");
        read_res(0, 3, 64'd2, "np0_frames");
        read_res(1, 0, 64'd1010, "np0_res1_kept");

        // Sweep 5: table unchanged, async reset mid-RUN, then a clean sweep.
        n_points = 2'd1; bit_limit = 64'd1000;
        pulse_start();
        tick();
        check("tbl_idx0", eng_prob_idx, 32'd0);
        check("tbl_unchanged", eng_prob_in, 64'd0);
        wait_state(ST_RUN, 200, "ar_reach_run", n);
        repeat (5) tick();
        #2 rstn = 1'b0;
        #1;
        check("ar_state", fsm_state, ST_IDLE);
        check("ar_busy", busy, 1'b0);
        check("ar_en", eng_en, 1'b0);
        check("ar_rstn", eng_rstn, 1'b0);
        check("ar_idx", eng_prob_idx, 32'hFFFF_FFFF);
        check("ar_prob", eng_prob_in, 64'd0);
        check("ar_il", eng_n_interleave, 4'd1);
        check("ar_res", res_data, 64'd0);
        check("ar_point", cur_point, 0);
        repeat (2) tick();
        rstn = 1'b1;
        bit_limit = 64'd100;
        pulse_start();
        check("post_erst", fsm_state, ST_ERST);
        wait_state(ST_DONE, 500, "post_reach_done", n);
        check("post_done", done, 1'b1);
        read_res(0, 0, 64'd110, "post_bits");
        read_res(0, 3, 64'd11, "post_frames");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
